// File: rtl/fighter_move_decoder_pkg.sv
// Move codes, combo states and button bundle shared by the fighter move decoder.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package fighter_move_decoder_pkg;

    typedef enum logic [3:0] {
        MOVE_NONE      = 4'd0,
        MOVE_PUNCH     = 4'd1,
        MOVE_KICK      = 4'd2,
        MOVE_JUMP      = 4'd3,
        MOVE_LOW_PUNCH = 4'd4,
        MOVE_LOW_KICK  = 4'd5,
        MOVE_FIREBALL  = 4'd6,
        MOVE_HURRICANE = 4'd7
    } move_e;

    typedef enum logic [1:0] {
        COMBO_IDLE      = 2'd0,
        COMBO_DOWN      = 2'd1,
        COMBO_DOWN_FWD  = 2'd2,
        COMBO_DOWN_BACK = 2'd3
    } combo_e;

    typedef struct packed {
        logic right;
        logic left;
        logic up;
        logic down;
        logic punch;
        logic kick;
    } btn_t;

    localparam logic [1:0] WALK_NONE = 2'b00;
    localparam logic [1:0] WALK_FWD  = 2'b01;
    localparam logic [1:0] WALK_BACK = 2'b10;

    // Returns {fwd, back} for a right/left pair as seen by the player.
    function automatic logic [1:0] fwd_back(input logic right, input logic left,
                                            input logic facing_right);
        return facing_right ? {right, left} : {left, right};
    endfunction

    function automatic logic [1:0] walk_code(input logic fwd, input logic back);
        if (fwd && !back)
            return WALK_FWD;
        else if (back && !fwd)
            return WALK_BACK;
        else
            return WALK_NONE;
    endfunction

endpackage

// File: rtl/fighter_move_decoder_move_fifo.sv
// Generic power-of-two FIFO holding pending move codes (module move_fifo).
// Latency: a push is visible on rd_vld/rd_dat the cycle after it is written.
// Backpressure: push while full is dropped unless a pop happens the same cycle.
module move_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_rdy,
    output logic         rd_vld,
    output logic [W-1:0] rd_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         empty;
    logic         full;
    logic         do_rd;
    logic         do_wr;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd  = rd_rdy && !empty;
    // The slot freed by a same-cycle pop makes room for the push.
    assign do_wr  = wr_vld && (!full || do_rd);
    assign rd_vld = !empty;
    assign rd_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr[AW-1:0]] <= wr_dat;
    end

endmodule

// File: rtl/fighter_move_decoder.sv
// Button levels to move commands with a down/fwd/back combo tracker; MOVE_QUEUE_EN selects a FIFO.
// Latency: move_valid, walk_dir and crouch appear 1 cycle after the input edge/level.
// Backpressure: move held until move_valid & move_ack; moves arriving with no room are dropped.
module fighter_move_decoder
    import fighter_move_decoder_pkg::*;
#(
    parameter int COMBO_WINDOW = 12_500_000,
    parameter int TMR_W        = 24,
    parameter int QUEUE_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_right,
    input  logic       btn_left,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_punch,
    input  logic       btn_kick,
    input  logic       facing_right,
    input  logic       move_ack,
    output logic       move_valid,
    output logic [3:0] move_code,
    output logic [1:0] walk_dir,
    output logic       crouch
);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(COMBO_WINDOW - 1);

    generate
        if (COMBO_WINDOW < 2 || (64'd1 << TMR_W) <= 64'(COMBO_WINDOW) ||
            QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_cfg
            $error("fighter_move_decoder: illegal parameter combination");
        end
    endgenerate

    btn_t             btn_now;
    btn_t             btn_prev;
    btn_t             btn_edge;
    logic [1:0]       lvl_fb;
    logic [1:0]       edge_fb;
    logic             e_fwd;
    logic             e_back;
    combo_e           state;
    logic [TMR_W-1:0] timer;
    logic             timed_out;
    move_e            new_move;
    logic             new_vld;

    assign btn_now   = {btn_right, btn_left, btn_up, btn_down, btn_punch, btn_kick};
    assign btn_edge  = btn_now & ~btn_prev;
    assign lvl_fb    = fwd_back(btn_right, btn_left, facing_right);
    assign edge_fb   = fwd_back(btn_edge.right, btn_edge.left, facing_right);
    assign e_fwd     = edge_fb[1];
    assign e_back    = edge_fb[0];
    assign timed_out = (state != COMBO_IDLE) && (timer == TMR_LAST);

    // Resolved from the current state, so an attack on the timeout cycle still completes the combo.
    always_comb begin
        new_move = MOVE_NONE;
        if (btn_edge.punch)
            new_move = (state == COMBO_DOWN_FWD) ? MOVE_FIREBALL :
                       (btn_down ? MOVE_LOW_PUNCH : MOVE_PUNCH);
        else if (btn_edge.kick)
            new_move = (state == COMBO_DOWN_BACK) ? MOVE_HURRICANE :
                       (btn_down ? MOVE_LOW_KICK : MOVE_KICK);
        else if (btn_edge.up && !btn_down)
            new_move = MOVE_JUMP;
    end

    assign new_vld = (new_move != MOVE_NONE);

    always_ff @(posedge clk) begin
        btn_prev <= btn_now;
        if (rst) begin
            state    <= COMBO_IDLE;
            timer    <= '0;
            walk_dir <= WALK_NONE;
            crouch   <= 1'b0;
        end else begin
            walk_dir <= walk_code(lvl_fb[1], lvl_fb[0]);
            crouch   <= btn_down & ~btn_up;
            if (btn_edge.punch || btn_edge.kick) begin
                state <= COMBO_IDLE;
                timer <= '0;
            end else if (state == COMBO_DOWN && e_fwd) begin
                state <= COMBO_DOWN_FWD;
                timer <= '0;
            end else if (state == COMBO_DOWN && e_back) begin
                state <= COMBO_DOWN_BACK;
                timer <= '0;
            end else if (btn_edge.down) begin
                state <= COMBO_DOWN;
                timer <= '0;
            end else if (e_fwd || e_back || (btn_edge.up && btn_down) || timed_out) begin
                // A jump (up without down) leaves the combo untouched.
                state <= COMBO_IDLE;
                timer <= '0;
            end else if (state != COMBO_IDLE) begin
                timer <= timer + TMR_W'(1);
            end
        end
    end

`ifdef MOVE_QUEUE_EN
    logic       q_vld;
    logic [3:0] q_dat;

    move_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .W     (4)
    ) u_move_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (new_vld),
        .wr_dat (new_move),
        .rd_rdy (move_ack),
        .rd_vld (q_vld),
        .rd_dat (q_dat)
    );

    assign move_valid = q_vld;
    assign move_code  = q_vld ? q_dat : 4'd0;
`else
    logic  hold_vld;
    move_e hold_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld  <= 1'b0;
            hold_code <= MOVE_NONE;
        end else if (new_vld && (!hold_vld || move_ack)) begin
            hold_vld  <= 1'b1;
            hold_code <= new_move;
        end else if (hold_vld && move_ack) begin
            hold_vld  <= 1'b0;
            hold_code <= MOVE_NONE;
        end
    end

    assign move_valid = hold_vld;
    assign move_code  = hold_code;
`endif

endmodule

// File: tb/tb_fighter_move_decoder.sv
// Directed scenarios plus randomized buttons checked against a window/queue reference model.
module tb_fighter_move_decoder;
    localparam int W  = 16;
    localparam int QD = 4;
`ifdef MOVE_QUEUE_EN
    localparam int CAP = QD;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_right, btn_left, btn_up, btn_down, btn_punch, btn_kick;
    logic       facing_right;
    logic       move_ack;
    logic       move_valid;
    logic [3:0] move_code;
    logic [1:0] walk_dir;
    logic       crouch;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fighter_move_decoder #(
        .COMBO_WINDOW (W),
        .TMR_W        (5),
        .QUEUE_DEPTH  (QD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_right    (btn_right),
        .btn_left     (btn_left),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .btn_punch    (btn_punch),
        .btn_kick     (btn_kick),
        .facing_right (facing_right),
        .move_ack     (move_ack),
        .move_valid   (move_valid),
        .move_code    (move_code),
        .walk_dir     (walk_dir),
        .crouch       (crouch)
    );

    // Reference model: combo stage (0 none, 1 down, 2 down+fwd, 3 down+back) valid for
    // W cycles after the step that entered it; pending moves kept in a bounded queue.
    bit [5:0] m_prev;
    int       m_stage = 0;
    int       m_age   = 0;
    int       m_q[$];
    int       m_walk  = 0;
    int       m_crouch = 0;

    task automatic model_step();
        bit e_r, e_l, e_u, e_d, e_p, e_k, e_f, e_b, l_f, l_b;
        int eff, mv;
        if (rst) begin
            m_q.delete();
            m_stage  = 0;
            m_age    = 0;
            m_walk   = 0;
            m_crouch = 0;
        end else begin
            e_r = btn_right & ~m_prev[0];
            e_l = btn_left  & ~m_prev[1];
            e_u = btn_up    & ~m_prev[2];
            e_d = btn_down  & ~m_prev[3];
            e_p = btn_punch & ~m_prev[4];
            e_k = btn_kick  & ~m_prev[5];
            e_f = facing_right ? e_r : e_l;
            e_b = facing_right ? e_l : e_r;
            l_f = facing_right ? btn_right : btn_left;
            l_b = facing_right ? btn_left : btn_right;
            m_age++;
            eff = (m_stage != 0 && m_age <= W) ? m_stage : 0;
            mv = 0;
            if (e_p)                 mv = (eff == 2) ? 6 : (btn_down ? 4 : 1);
            else if (e_k)            mv = (eff == 3) ? 7 : (btn_down ? 5 : 2);
            else if (e_u && !btn_down) mv = 3;
            if (e_p || e_k)               m_stage = 0;
            else if (eff == 1 && e_f)     begin m_stage = 2; m_age = 0; end
            else if (eff == 1 && e_b)     begin m_stage = 3; m_age = 0; end
            else if (e_d)                 begin m_stage = 1; m_age = 0; end
            else if (e_f || e_b || (e_u && btn_down)) m_stage = 0;
            else                          m_stage = eff;
            if (m_q.size() > 0 && move_ack) m_q.delete(0);
            if (mv != 0 && m_q.size() < CAP) m_q.push_back(mv);
            m_walk   = (l_f && !l_b) ? 1 : ((l_b && !l_f) ? 2 : 0);
            m_crouch = (btn_down && !btn_up) ? 1 : 0;
        end
        m_prev = {btn_kick, btn_punch, btn_down, btn_up, btn_left, btn_right};
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btns(input bit r, input bit l, input bit u, input bit d,
                            input bit p, input bit k);
        btn_right = r; btn_left = l; btn_up = u; btn_down = d; btn_punch = p; btn_kick = k;
    endtask

    task automatic settle();
        set_btns(0, 0, 0, 0, 0, 0);
        move_ack = 1'b1;
        repeat (CAP + 1) tick();
        move_ack = 1'b0;
        repeat (W + 2) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_btns(0, 0, 0, 0, 1, 0);
        repeat (3) tick();
        n_total++;
        if (move_valid !== 1'b0 || move_code !== 4'd0 || walk_dir !== 2'b00 || crouch !== 1'b0)
            $display("FAIL reset_state: valid=%0b code=%0d walk=%b crouch=%0b, want 0/0/00/0",
                     move_valid, move_code, walk_dir, crouch);
        else n_pass++;
        rst = 1'b0;
        tick();
        tick();
        n_total++;
        if (move_valid !== 1'b0)
            $display("FAIL held_through_reset: valid=%0b, want 0", move_valid);
        else n_pass++;
    endtask

    task automatic test_punch_ack();
        set_btns(0, 0, 0, 0, 0, 0);
        tick();
        set_btns(0, 0, 0, 0, 1, 0);
        tick();
        n_total++;
        if (move_valid !== 1'b1 || move_code !== 4'd1)
            $display("FAIL punch_latency: valid=%0b code=%0d, want 1/1", move_valid, move_code);
        else n_pass++;
        set_btns(0, 0, 0, 0, 0, 0);
        move_ack = 1'b1;
        tick();
        move_ack = 1'b0;
        n_total++;
        if (move_valid !== 1'b0 || move_code !== 4'd0)
            $display("FAIL punch_ack: valid=%0b code=%0d, want 0/0", move_valid, move_code);
        else n_pass++;
        settle();
    endtask

    task automatic test_fireball(input bit face);
        facing_right = face;
        set_btns(0, 0, 0, 1, 0, 0);
        tick();
        repeat (4) tick();
        set_btns(face, !face, 0, 1, 0, 0);
        tick();
        repeat (4) tick();
        set_btns(face, !face, 0, 1, 1, 0);
        tick();
        n_total++;
        if (move_valid !== 1'b1 || move_code !== 4'd6)
            $display("FAIL fireball_face%0d: valid=%0b code=%0d, want 1/6", face, move_valid, move_code);
        else n_pass++;
        settle();
        facing_right = 1'b1;
    endtask

    task automatic test_hurricane();
        facing_right = 1'b1;
        set_btns(0, 0, 0, 1, 0, 0);
        tick();
        set_btns(0, 1, 0, 1, 0, 0);
        tick();
        set_btns(0, 1, 0, 1, 0, 1);
        tick();
        n_total++;
        if (move_valid !== 1'b1 || move_code !== 4'd7)
            $display("FAIL hurricane: valid=%0b code=%0d, want 1/7", move_valid, move_code);
        else n_pass++;
        settle();
    endtask

    task automatic test_timeout();
        set_btns(0, 0, 0, 1, 0, 0);
        tick();
        set_btns(1, 0, 0, 1, 0, 0);
        tick();
        set_btns(0, 0, 0, 0, 0, 0);
        repeat (20) tick();
        set_btns(0, 0, 0, 0, 1, 0);
        tick();
        n_total++;
        if (move_valid !== 1'b1 || move_code !== 4'd1)
            $display("FAIL combo_timeout: valid=%0b code=%0d, want 1/1", move_valid, move_code);
        else n_pass++;
        settle();
    endtask

    // Punch k cycles after the fwd step, down held throughout.
    task automatic test_window_edge(input int k, input logic [3:0] want);
        set_btns(0, 0, 0, 1, 0, 0);
        tick();
        set_btns(1, 0, 0, 1, 0, 0);
        tick();
        repeat (k - 1) tick();
        set_btns(1, 0, 0, 1, 1, 0);
        tick();
        n_total++;
        if (move_valid !== 1'b1 || move_code !== want)
            $display("FAIL window_k%0d: valid=%0b code=%0d, want 1/%0d", k, move_valid, move_code, want);
        else n_pass++;
        settle();
    endtask

    task automatic test_same_cycle();
        set_btns(0, 0, 0, 1, 0, 0);
        tick();
        set_btns(0, 0, 0, 1, 1, 1);
        tick();
        n_total++;
        if (move_valid !== 1'b1 || move_code !== 4'd4)
            $display("FAIL same_cycle_prio: valid=%0b code=%0d, want 1/4", move_valid, move_code);
        else n_pass++;
        move_ack = 1'b1;
        tick();
        move_ack = 1'b0;
        tick();
        n_total++;
        if (move_valid !== 1'b0)
            $display("FAIL same_cycle_single: valid=%0b code=%0d, want valid 0", move_valid, move_code);
        else n_pass++;
        settle();
    endtask

`ifdef MOVE_QUEUE_EN
    task automatic test_full();
        int want[4] = '{1, 2, 3, 4};
        set_btns(0, 0, 0, 0, 1, 0); tick();
        set_btns(0, 0, 0, 0, 0, 0); tick();
        set_btns(0, 0, 0, 0, 0, 1); tick();
        set_btns(0, 0, 0, 0, 0, 0); tick();
        set_btns(0, 0, 1, 0, 0, 0); tick();
        set_btns(0, 0, 0, 0, 0, 0); tick();
        set_btns(0, 0, 0, 1, 0, 0); tick();
        set_btns(0, 0, 0, 1, 1, 0); tick();
        set_btns(0, 0, 0, 1, 0, 0); tick();
        set_btns(0, 0, 0, 1, 0, 1); tick();
        set_btns(0, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (move_valid !== 1'b1 || move_code !== 4'(want[i]))
                $display("FAIL queue_order_%0d: valid=%0b code=%0d, want 1/%0d",
                         i, move_valid, move_code, want[i]);
            else n_pass++;
            move_ack = 1'b1;
            tick();
            move_ack = 1'b0;
        end
        n_total++;
        if (move_valid !== 1'b0)
            $display("FAIL queue_fifth_dropped: valid=%0b code=%0d, want valid 0", move_valid, move_code);
        else n_pass++;
        settle();
    endtask
`else
    task automatic test_full();
        set_btns(0, 0, 0, 0, 1, 0); tick();
        set_btns(0, 0, 0, 0, 0, 0); tick();
        set_btns(0, 0, 0, 0, 0, 1); tick();
        set_btns(0, 0, 0, 0, 0, 0);
        n_total++;
        if (move_valid !== 1'b1 || move_code !== 4'd1)
            $display("FAIL busy_hold: valid=%0b code=%0d, want 1/1", move_valid, move_code);
        else n_pass++;
        move_ack = 1'b1;
        tick();
        move_ack = 1'b0;
        tick();
        n_total++;
        if (move_valid !== 1'b0)
            $display("FAIL busy_drop: valid=%0b code=%0d, want valid 0", move_valid, move_code);
        else n_pass++;
        settle();
    endtask
`endif

    task automatic test_back_to_back();
        set_btns(0, 0, 0, 0, 1, 0); tick();
        set_btns(0, 0, 0, 0, 0, 1);
        move_ack = 1'b1;
        tick();
        move_ack = 1'b0;
        n_total++;
        if (move_valid !== 1'b1 || move_code !== 4'd2)
            $display("FAIL back_to_back: valid=%0b code=%0d, want 1/2", move_valid, move_code);
        else n_pass++;
        settle();
    endtask

    task automatic test_walk_crouch();
        facing_right = 1'b1;
        set_btns(1, 0, 0, 0, 0, 0); tick();
        n_total++;
        if (walk_dir !== 2'b01) $display("FAIL walk_fwd: walk=%b, want 01", walk_dir);
        else n_pass++;
        facing_right = 1'b0;
        tick();
        n_total++;
        if (walk_dir !== 2'b10) $display("FAIL walk_back: walk=%b, want 10", walk_dir);
        else n_pass++;
        set_btns(1, 1, 0, 1, 0, 0); tick();
        n_total++;
        if (walk_dir !== 2'b00 || crouch !== 1'b1)
            $display("FAIL walk_both_crouch: walk=%b crouch=%0b, want 00/1", walk_dir, crouch);
        else n_pass++;
        set_btns(0, 0, 1, 1, 0, 0); tick();
        n_total++;
        if (crouch !== 1'b0 || move_valid !== 1'b0)
            $display("FAIL crouch_up: crouch=%0b valid=%0b, want 0/0", crouch, move_valid);
        else n_pass++;
        facing_right = 1'b1;
        settle();
    endtask

    task automatic test_reset_mid();
        set_btns(0, 0, 0, 0, 1, 0); tick();
        set_btns(0, 0, 0, 0, 0, 0); tick();
        set_btns(0, 0, 0, 1, 0, 0); tick();
        set_btns(1, 0, 0, 1, 0, 0); tick();
        rst = 1'b1;
        tick();
        n_total++;
        if (move_valid !== 1'b0 || move_code !== 4'd0 || walk_dir !== 2'b00 || crouch !== 1'b0)
            $display("FAIL reset_mid: valid=%0b code=%0d walk=%b crouch=%0b, want 0/0/00/0",
                     move_valid, move_code, walk_dir, crouch);
        else n_pass++;
        set_btns(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        set_btns(0, 0, 0, 0, 1, 0); tick();
        n_total++;
        if (move_valid !== 1'b1 || move_code !== 4'd1)
            $display("FAIL punch_after_reset: valid=%0b code=%0d, want 1/1", move_valid, move_code);
        else n_pass++;
        settle();
    endtask

    task automatic test_random();
        int exp_code;
        bit exp_vld;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) btn_right = ~btn_right;
            if ($urandom_range(0, 7) == 0) btn_left  = ~btn_left;
            if ($urandom_range(0, 9) == 0) btn_up    = ~btn_up;
            if ($urandom_range(0, 5) == 0) btn_down  = ~btn_down;
            if ($urandom_range(0, 7) == 0) btn_punch = ~btn_punch;
            if ($urandom_range(0, 7) == 0) btn_kick  = ~btn_kick;
            if ($urandom_range(0, 63) == 0) facing_right = ~facing_right;
            move_ack = ($urandom_range(0, 3) == 0);
            rst      = ($urandom_range(0, 499) == 0);
            tick();
            exp_vld  = (m_q.size() > 0);
            exp_code = exp_vld ? m_q[0] : 0;
            n_total++;
            if (move_valid !== exp_vld || move_code !== 4'(exp_code))
                $display("FAIL rand_move @%0d: valid=%0b code=%0d, want %0b/%0d",
                         n, move_valid, move_code, exp_vld, exp_code);
            else n_pass++;
            n_total++;
            if (walk_dir !== 2'(m_walk))
                $display("FAIL rand_walk @%0d: walk=%b, want %0d", n, walk_dir, m_walk);
            else n_pass++;
            n_total++;
            if (crouch !== 1'(m_crouch))
                $display("FAIL rand_crouch @%0d: crouch=%0b, want %0d", n, crouch, m_crouch);
            else n_pass++;
        end
        rst = 1'b0;
        move_ack = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        facing_right = 1'b1;
        move_ack     = 1'b0;
        set_btns(0, 0, 0, 0, 0, 0);
        test_reset();
        test_punch_ack();
        test_fireball(1'b1);
        test_fireball(1'b0);
        test_hurricane();
        test_timeout();
        test_window_edge(W, 4'd6);
        test_window_edge(W + 1, 4'd4);
        test_same_cycle();
        test_full();
        test_back_to_back();
        test_walk_crouch();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
